bpu_update_queue: RTL and testbench

Buffers branch outcomes resolved in the dual-issue backend and replays them, one per cycle, onto the predictor's training port (update_en / pc_dispatch / taken_actual) consumed by the dual-lane BHT/PHT predictor. It sits between execute-stage branch resolution and the front-end predictor. It decouples up to two resolutions per cycle from the single-write update port, and preserves program order.

---
 rtl/bpu_pkg.sv | 16 +
 rtl/bpu_update_fifo.sv | 93 +++++++++
 rtl/bpu_update_queue.sv | 110 +++++++++++
 tb/tb_bpu_update_queue.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/bpu_pkg.sv
// Shared types and constants for the branch-predictor update path.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package bpu_pkg;

  localparam int BPU_UPDATE_DEPTH = 8;
  localparam int BPU_LANES        = 2;

  // One resolved branch as buffered on its way to predictor training.
  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic        pred_taken;
  } bpu_update_t;

endpackage

// File: rtl/bpu_update_fifo.sv
// 2-write/1-read circular buffer of resolved branches with count and pointers.
// Latency: an entry written at edge E is visible at rd_dat_o after E.
// Backpressure: wr_rdy_o = (count <= DEPTH-2); writes while not ready are ignored.
// Ports: clk/rst (sync, active-high); wr_en_i[1:0], wr0_dat_i, wr1_dat_i (lane 0 older);
//        rd_en_i pop request; rd_vld_o queue non-empty; rd_dat_o head entry.
// Macro BPU_PERF_CNT_EN: when undefined the pred_taken field is not stored.
module bpu_update_fifo
  import bpu_pkg::*;
#(
  parameter int DEPTH = BPU_UPDATE_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BPU_LANES-1:0] wr_en_i,
  input  bpu_update_t          wr0_dat_i,
  input  bpu_update_t          wr1_dat_i,
  output logic                 wr_rdy_o,
  input  logic                 rd_en_i,
  output logic                 rd_vld_o,
  output bpu_update_t          rd_dat_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]          pc_mem    [DEPTH];
  logic                 taken_mem [DEPTH];
`ifdef BPU_PERF_CNT_EN
  logic                 pred_mem  [DEPTH];
`endif

  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [BPU_LANES-1:0] wr_acc;
  logic [AW-1:0]        wr1_idx;
  logic [CW-1:0]        push_n;
  logic                 pop;

  assign wr_rdy_o = (count_q <= CW'(DEPTH - 2));
  assign wr_acc   = wr_en_i & {BPU_LANES{wr_rdy_o}};
  assign rd_vld_o = (count_q != '0);
  assign pop      = rd_en_i & rd_vld_o;
  assign push_n   = CW'(wr_acc[0]) + CW'(wr_acc[1]);
  // Lane 1 packs directly behind lane 0 so a lone lane-1 write leaves no hole.
  assign wr1_idx  = wr_ptr_q + AW'(wr_acc[0]);

  // Power-of-two depth: pointer arithmetic wraps naturally at AW bits.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push_n);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + push_n - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc[0]) begin
      pc_mem[wr_ptr_q]    <= wr0_dat_i.pc;
      taken_mem[wr_ptr_q] <= wr0_dat_i.taken;
    end
    if (wr_acc[1]) begin
      pc_mem[wr1_idx]     <= wr1_dat_i.pc;
      taken_mem[wr1_idx]  <= wr1_dat_i.taken;
    end
  end

`ifdef BPU_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (wr_acc[0]) pred_mem[wr_ptr_q] <= wr0_dat_i.pred_taken;
    if (wr_acc[1]) pred_mem[wr1_idx]  <= wr1_dat_i.pred_taken;
  end
  assign rd_dat_o.pred_taken = pred_mem[rd_ptr_q];
`else
  logic unused_pred;
  assign unused_pred         = wr0_dat_i.pred_taken ^ wr1_dat_i.pred_taken;
  assign rd_dat_o.pred_taken = 1'b0;
`endif

  assign rd_dat_o.pc    = pc_mem[rd_ptr_q];
  assign rd_dat_o.taken = taken_mem[rd_ptr_q];

endmodule

// File: rtl/bpu_update_queue.sv
// Buffers up to two resolved branches per cycle and replays them in order, one per cycle, to predictor training.
// Latency: branch accepted at edge E drives update_en=1 after edge E+1 (2 cycles on an empty queue).
// Backpressure: resolve_ready = (count <= DEPTH-2); lanes offered while not ready are ignored and must be held.
// Ports: clk, rst (sync, active-high); resolve_valid/pc/taken/pred_taken (2 lanes, pc lane i at [32*i +: 32]);
//        resolve_ready; update_en/pc_dispatch/taken_actual (registered); branch_cnt/mispredict_cnt.
// Macro BPU_PERF_CNT_EN: enables the two performance counters; otherwise they read 0.
module bpu_update_queue
  import bpu_pkg::*;
#(
  parameter int DEPTH = BPU_UPDATE_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  resolve_valid,
  input  logic [63:0] resolve_pc,
  input  logic [1:0]  resolve_taken,
  input  logic [1:0]  resolve_pred_taken,
  output logic        resolve_ready,
  output logic        update_en,
  output logic [31:0] pc_dispatch,
  output logic        taken_actual,
  output logic [31:0] mispredict_cnt,
  output logic [31:0] branch_cnt
);

  bpu_update_t wr0_dat, wr1_dat, rd_dat;
  logic        rd_vld;

  logic        update_en_q, update_en_d;
  logic [31:0] pc_q, pc_d;
  logic        taken_q, taken_d;

  assign wr0_dat = '{pc: resolve_pc[31:0],  taken: resolve_taken[0], pred_taken: resolve_pred_taken[0]};
  assign wr1_dat = '{pc: resolve_pc[63:32], taken: resolve_taken[1], pred_taken: resolve_pred_taken[1]};

  // The head is always popped when present: training never stalls.
  bpu_update_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (resolve_valid),
    .wr0_dat_i (wr0_dat),
    .wr1_dat_i (wr1_dat),
    .wr_rdy_o  (resolve_ready),
    .rd_en_i   (1'b1),
    .rd_vld_o  (rd_vld),
    .rd_dat_o  (rd_dat)
  );

  logic unused_rd_pred;
  assign unused_rd_pred = rd_dat.pred_taken;

  // PC and direction hold their last trained value while the queue is empty.
  always_comb begin
    update_en_d = rd_vld;
    pc_d        = pc_q;
    taken_d     = taken_q;
    if (rd_vld) begin
      pc_d    = rd_dat.pc;
      taken_d = rd_dat.taken;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      update_en_q <= 1'b0;
      pc_q        <= '0;
      taken_q     <= 1'b0;
    end else begin
      update_en_q <= update_en_d;
      pc_q        <= pc_d;
      taken_q     <= taken_d;
    end
  end

  assign update_en    = update_en_q;
  assign pc_dispatch  = pc_q;
  assign taken_actual = taken_q;

`ifdef BPU_PERF_CNT_EN
  logic [1:0]  acc;
  logic [1:0]  mis;
  logic [31:0] branch_cnt_q, branch_cnt_d;
  logic [31:0] mispredict_cnt_q, mispredict_cnt_d;

  assign acc = resolve_valid & {2{resolve_ready}};
  assign mis = acc & (resolve_taken ^ resolve_pred_taken);

  always_comb begin
    branch_cnt_d     = branch_cnt_q + 32'(acc[0]) + 32'(acc[1]);
    mispredict_cnt_d = mispredict_cnt_q + 32'(mis[0]) + 32'(mis[1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end

  assign branch_cnt     = branch_cnt_q;
  assign mispredict_cnt = mispredict_cnt_q;
`else
  assign branch_cnt     = '0;
  assign mispredict_cnt = '0;
`endif

endmodule

// File: tb/tb_bpu_update_queue.sv
// Randomized and directed bench for bpu_update_queue against a queue-based reference model.
// Latency: n/a (testbench).
// Backpressure: stimulus holds offered lanes until the model says they were accepted.
module tb_bpu_update_queue;

  localparam int DEPTH = 8;

  logic        clk;
  logic        rst;
  logic [1:0]  resolve_valid;
  logic [63:0] resolve_pc;
  logic [1:0]  resolve_taken;
  logic [1:0]  resolve_pred_taken;
  logic        resolve_ready;
  logic        update_en;
  logic [31:0] pc_dispatch;
  logic        taken_actual;
  logic [31:0] mispredict_cnt;
  logic [31:0] branch_cnt;

  bpu_update_queue #(.DEPTH(DEPTH)) dut (
    .clk                (clk),
    .rst                (rst),
    .resolve_valid      (resolve_valid),
    .resolve_pc         (resolve_pc),
    .resolve_taken      (resolve_taken),
    .resolve_pred_taken (resolve_pred_taken),
    .resolve_ready      (resolve_ready),
    .update_en          (update_en),
    .pc_dispatch        (pc_dispatch),
    .taken_actual       (taken_actual),
    .mispredict_cnt     (mispredict_cnt),
    .branch_cnt         (branch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        taken;
  } ent_t;

  ent_t        mq[$];
  logic        exp_en;
  logic [31:0] exp_pc;
  logic        exp_taken;
  logic [31:0] exp_br;
  logic [31:0] exp_mis;
  int          total;
  int          bad;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h want=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] perf_exp(input logic [31:0] v);
`ifdef BPU_PERF_CNT_EN
    return v;
`else
    return 32'd0;
`endif
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, ".update_en"}, 32'(update_en), 32'(exp_en));
    check({tag, ".pc_dispatch"}, pc_dispatch, exp_pc);
    check({tag, ".taken_actual"}, 32'(taken_actual), 32'(exp_taken));
    check({tag, ".branch_cnt"}, branch_cnt, perf_exp(exp_br));
    check({tag, ".mispredict_cnt"}, mispredict_cnt, perf_exp(exp_mis));
  endtask

  // One clock of stimulus. acc reports whether the offered lanes were taken,
  // decided purely from the model's occupancy.
  task automatic cycle(input string tag, input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] pc1,
                       input logic [1:0] t, input logic [1:0] p, output bit acc);
    ent_t e;
    resolve_valid      = v;
    resolve_pc         = {pc1, pc0};
    resolve_taken      = t;
    resolve_pred_taken = p;
    #1;
    acc = (mq.size() <= DEPTH - 2);
    check({tag, ".ready"}, 32'(resolve_ready), 32'(acc));
    @(posedge clk);
    #1;
    if (mq.size() > 0) begin
      e         = mq.pop_front();
      exp_en    = 1'b1;
      exp_pc    = e.pc;
      exp_taken = e.taken;
    end else begin
      exp_en = 1'b0;
    end
    if (acc) begin
      for (int l = 0; l < 2; l++) begin
        if (v[l]) begin
          e.pc    = (l == 0) ? pc0 : pc1;
          e.taken = t[l];
          mq.push_back(e);
          exp_br++;
          if (t[l] != p[l]) exp_mis++;
        end
      end
    end
    check_outputs(tag);
  endtask

  task automatic idle(input string tag, input int n);
    bit a;
    for (int i = 0; i < n; i++) cycle(tag, 2'b00, 32'h0, 32'h0, 2'b00, 2'b00, a);
  endtask

  task automatic do_reset(input string tag);
    rst           = 1'b1;
    resolve_valid = 2'b00;
    @(posedge clk);
    #1;
    mq.delete();
    exp_en    = 1'b0;
    exp_pc    = 32'h0;
    exp_taken = 1'b0;
    exp_br    = 32'h0;
    exp_mis   = 32'h0;
    check({tag, ".rst_ready"}, 32'(resolve_ready), 32'd1);
    check_outputs({tag, ".rst"});
    rst = 1'b0;
  endtask

  initial begin
    bit          a;
    logic [31:0] npc;
    logic [1:0]  rv;
    logic [31:0] rp0, rp1;
    logic [1:0]  rt, rpt;

    total              = 0;
    bad                = 0;
    rst                = 1'b1;
    resolve_valid      = 2'b00;
    resolve_pc         = '0;
    resolve_taken      = 2'b00;
    resolve_pred_taken = 2'b00;

    do_reset("init");
    idle("post_rst", 1);

    // Single lane-0 branch: update two edges later, then idle again.
    cycle("single", 2'b01, 32'h1C000010, 32'h0, 2'b01, 2'b00, a);
    check("single.not_yet", 32'(update_en), 32'd0);
    idle("single", 3);

    // Dual accept: lane 0 trains first, lane 1 next cycle.
    cycle("dual", 2'b11, 32'h100, 32'h104, 2'b10, 2'b10, a);
    idle("dual", 4);

    // Lane-1-only: exactly one update, no phantom lane-0 entry.
    cycle("lane1", 2'b10, 32'hDEAD0000, 32'h200, 2'b10, 2'b00, a);
    idle("lane1", 4);
    check("lane1.empty", 32'(mq.size()), 32'd0);

    // Sustained dual input: fills, throttles, wraps pointers.
    npc = 32'h1000;
    for (int i = 0; i < 24; i++) begin
      cycle("fill", 2'b11, npc, npc + 32'h4, {npc[3], npc[2]}, 2'b00, a);
      if (a) npc = npc + 32'h8;
    end
    idle("fill_drain", 10);

    // Reset with five entries queued discards them.
    npc = 32'h3000;
    for (int i = 0; i < 4; i++) begin
      cycle("prerst", 2'b11, npc, npc + 32'h4, 2'b01, 2'b10, a);
      npc = npc + 32'h8;
    end
    check("prerst.depth", 32'(mq.size()), 32'd5);
    do_reset("midrst");
    idle("midrst_after", 6);

    // Ten branches, three of them mispredicted.
    cycle("perf", 2'b11, 32'h400, 32'h404, 2'b01, 2'b00, a);
    cycle("perf", 2'b11, 32'h408, 32'h40C, 2'b11, 2'b11, a);
    cycle("perf", 2'b11, 32'h410, 32'h414, 2'b10, 2'b00, a);
    cycle("perf", 2'b11, 32'h418, 32'h41C, 2'b00, 2'b00, a);
    cycle("perf", 2'b11, 32'h420, 32'h424, 2'b10, 2'b11, a);
    idle("perf_drain", 8);
    check("perf.branch_cnt", branch_cnt, perf_exp(32'd10));
    check("perf.mispredict_cnt", mispredict_cnt, perf_exp(32'd3));

    // Random traffic; offered lanes are held until accepted.
    rv  = 2'b00;
    rp0 = 32'h0;
    rp1 = 32'h0;
    rt  = 2'b00;
    rpt = 2'b00;
    for (int i = 0; i < 400; i++) begin
      if (rv == 2'b00) begin
        rv  = 2'($urandom_range(0, 3));
        rp0 = $urandom & 32'hFFFF_FFFC;
        rp1 = $urandom & 32'hFFFF_FFFC;
        rt  = 2'($urandom);
        rpt = 2'($urandom);
      end
      cycle("rand", rv, rp0, rp1, rt, rpt, a);
      if (a) rv = 2'b00;
    end
    idle("rand_drain", 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
